// File: rtl/switch_config_loader.sv
// switch_config_loader
//   Sequences configuration of a daisy-chain of NUM_BOXES switch boxes. Config
//   words arrive one per box on a valid/ready stream. Each accepted word is
//   registered onto cfg_out and announced with a one-cycle cfg_shift strobe.
//   Every 2-bit mux-select field of each word is checked. The value 2'b11 is
//   illegal for a 3:1 mux. The index of the first offending word is recorded,
//   and the error flag stays set until the next start.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a load sequence (sampled in IDLE only)
//   cfg_valid  host presents a word on cfg_data
//   cfg_data   config word; bits [2i+1:2i] form select field i
//   cfg_ready  loader accepts cfg_data this cycle (high in LOAD only)
//   cfg_out    registered word driven to the switch-box chain
//   cfg_shift  one-cycle strobe: chain captures cfg_out
//   busy       high while in LOAD or DONE
//   done       one-cycle pulse marking sequence completion
//   cfg_err    sticky flag: an accepted word contained a 2'b11 field
//   err_index  0-based index of the first offending word
module switch_config_loader #(
  parameter int NUM_BOXES = 4,
  parameter int CFG_W     = 16,
  parameter int CNT_W     = $clog2(NUM_BOXES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_shift,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] err_index
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BOXES - 1);

  // True when any 2-bit select field of the word holds the illegal code 2'b11.
  function automatic logic has_bad_field(input logic [CFG_W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < CFG_W / 2; i++) begin
      if (word[2*i +: 2] == 2'b11) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CFG_W-1:0] out_q, out_d;
  logic             shift_q, shift_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             xfer_s;

  // Ready depends on state only, so the host can never combinationally loop
  // through valid.
  assign cfg_ready = (state_q == ST_LOAD);
  assign xfer_s    = cfg_valid & cfg_ready;

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    shift_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = {CNT_W{1'b0}};
          err_d   = 1'b0;
          idx_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          out_d   = cfg_data;
          shift_d = 1'b1;
          // Only the first offending word is recorded.
          if (has_bad_field(cfg_data) && !err_q) begin
            err_d = 1'b1;
            idx_d = count_q;
          end else begin
            err_d = err_q;
          end
          // The counter saturates at the last index instead of wrapping.
          // done is registered together with the final shift, so the two
          // coincide.
          if (count_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= {CNT_W{1'b0}};
      out_q   <= {CFG_W{1'b0}};
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign cfg_out   = out_q;
  assign cfg_shift = shift_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign cfg_err   = err_q;
  assign err_index = idx_q;

endmodule
